// File: rtl/timer_sample_arb.sv
// timer_sample_arb: round-robin arbiter that serialises timestamp sample
// requests onto one timer core and returns the captured counter value.
module timer_sample_arb #(
   parameter int DATA_W = 32,
   parameter int N_REQ  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stop,
   input  logic [N_REQ-1:0]    req,
   output logic [N_REQ-1:0]    ack,
   output logic [2*DATA_W-1:0] value,
   output logic                busy,
   output logic                TIMER_ENABLE,
   output logic                TIMER_SAMPLE,
   input  logic [2*DATA_W-1:0] TIMER_VALUE
);

   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SAMPLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [IW-1:0]         r_last;
   logic                  r_en;
   logic                  r_sample;
   logic                  r_busy;
   logic [N_REQ-1:0]      r_ack;
   logic [2*DATA_W-1:0]   r_value;

   logic [IW-1:0]         w_gnt;
   logic [IW-1:0]         w_idx;
   logic                  w_hit;
   logic [N_REQ-1:0]      w_onehot;

   assign TIMER_ENABLE = r_en;
   assign TIMER_SAMPLE = r_sample;
   assign busy         = r_busy;
   assign ack          = r_ack;
   assign value        = r_value;

   assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_last;

   // Rotating search for the first live request after the previous winner.
   always_comb begin
      w_gnt = r_last;
      w_hit = 1'b0;
      w_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_idx = IW'((int'(r_last) + k) % N_REQ);
         if (!w_hit && req[w_idx]) begin
            w_hit = 1'b1;
            w_gnt = w_idx;
         end
      end
   end

   // Timer enable runs on its own; stop has priority over start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en <= 1'b0;
      end else if (stop) begin
         r_en <= 1'b0;
      end else if (start) begin
         r_en <= 1'b1;
      end
   end

   // Sample sequencer: strobe the core, wait for its snapshot, capture, ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_last   <= IW'(N_REQ - 1);
         r_sample <= 1'b0;
         r_busy   <= 1'b0;
         r_ack    <= '0;
         r_value  <= '0;
      end else begin
         r_sample <= 1'b0;
         r_ack    <= '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_state  <= S_SAMPLE;
                  r_last   <= w_gnt;
                  r_sample <= 1'b1;
                  r_busy   <= 1'b1;
               end
            end
            S_SAMPLE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_state <= S_DONE;
               r_value <= TIMER_VALUE;
               r_ack   <= w_onehot;
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_sample_arb.sv
// tb_timer_sample_arb: directed bench with a transaction-timeline model
// of the arbiter and a simple timer core model driving TIMER_VALUE.
module tb_timer_sample_arb;

   localparam int DW = 32;
   localparam int N  = 4;

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic          stop  = 1'b0;
   logic [N-1:0]  req   = '0;
   logic [N-1:0]  ack;
   logic [63:0]   value;
   logic          busy;
   logic          en;
   logic          ts;
   logic [63:0]   tval;

   timer_sample_arb #(.DATA_W(DW), .N_REQ(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .req          (req),
      .ack          (ack),
      .value        (value),
      .busy         (busy),
      .TIMER_ENABLE (en),
      .TIMER_SAMPLE (ts),
      .TIMER_VALUE  (tval)
   );

   always #5 clk = ~clk;

   // Timer core: free counter while enabled, snapshot register on strobe.
   logic [63:0] cnt  = '0;
   logic [63:0] snap = '0;
   always @(posedge clk) begin
      if (ts) snap <= cnt;
      if (en) cnt <= cnt + 64'd1;
   end
   assign tval = snap;

   int n_chk = 0;
   int n_err = 0;

   // Model: one transaction accepted at cycle m_s occupies m_s+1..m_s+3.
   bit          m_act = 0;
   int          m_s   = 0;
   int          m_g   = 0;
   int          m_last = N - 1;
   logic        m_en  = 1'b0;
   logic [63:0] m_cap = '0;
   logic [63:0] m_val = '0;
   logic [N-1:0] drop = '0;
   int          cyc_n = 0;

   int          ts_q[$];
   int          ack_c[$];
   logic [N-1:0] ack_v[$];
   logic [63:0] val_q[$];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d got %0h want %0h", nm, cyc_n, act, exp);
      end
   endtask

   task automatic clear_log();
      ts_q.delete();
      ack_c.delete();
      ack_v.delete();
      val_q.delete();
   endtask

   task automatic model_step();
      int  d;
      bit  idle;
      bit  hit;
      if (rst) begin
         m_act  = 0;
         m_last = N - 1;
         m_en   = 1'b0;
         m_val  = '0;
      end else begin
         d    = cyc_n - m_s;
         idle = !m_act || d >= 4;
         if (m_act && d == 1) m_cap = cnt;
         if (m_act && d == 2) m_val = m_cap;
         if (stop) m_en = 1'b0;
         else if (start) m_en = 1'b1;
         if (idle && |req) begin
            hit = 0;
            for (int k = 1; k <= N; k++) begin
               int i;
               i = (m_last + k) % N;
               if (!hit && req[i]) begin
                  hit = 1;
                  m_g = i;
               end
            end
            m_act  = 1;
            m_s    = cyc_n;
            m_last = m_g;
         end
      end
   endtask

   task automatic cyc();
      int           d;
      logic         e_busy;
      logic         e_ts;
      logic [N-1:0] e_ack;
      logic [N-1:0] one;
      model_step();
      @(negedge clk);
      cyc_n++;
      one    = 1;
      d      = cyc_n - m_s;
      e_busy = m_act && d >= 1 && d <= 3;
      e_ts   = m_act && d == 1;
      e_ack  = (m_act && d == 3) ? (one << m_g) : '0;
      chk("ack", 64'(ack), 64'(e_ack));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("sample", 64'(ts), 64'(e_ts));
      chk("enable", 64'(en), 64'(m_en));
      chk("value", value, m_val);
      if (ts) ts_q.push_back(cyc_n);
      if (ack != '0) begin
         ack_c.push_back(cyc_n);
         ack_v.push_back(ack);
         val_q.push_back(value);
      end
      for (int i = 0; i < N; i++)
         if (e_ack[i] && drop[i]) req[i] = 1'b0;
   endtask

   initial begin
      int t0;
      // Reset state
      repeat (3) cyc();
      chk("rst_value", value, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);

      // Single request on requester 2 at cycle 10
      rst = 1'b0;
      cyc_n = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      drop = '1;
      repeat (9) cyc();
      clear_log();
      req = 4'b0100;
      repeat (6) cyc();
      chk("t1_nts", 64'(ts_q.size()), 64'd1);
      chk("t1_ts_cyc", 64'(ts_q[0]), 64'd11);
      chk("t1_nack", 64'(ack_c.size()), 64'd1);
      chk("t1_ack_cyc", 64'(ack_c[0]), 64'd13);
      chk("t1_ack", 64'(ack_v[0]), 64'h4);
      chk("t1_val", val_q[0], 64'd10);

      // Full contention after a fresh reset
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      clear_log();
      req = 4'b1111;
      t0 = cyc_n;
      repeat (18) cyc();
      chk("t2_nack", 64'(ack_c.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         chk("t2_order", 64'(ack_v[k]), 64'(1 << k));
         chk("t2_cyc", 64'(ack_c[k]), 64'(t0 + 3 + 4 * k));
         if (k > 0) begin
            chk("t2_incr", 64'(val_q[k] > val_q[k-1]), 64'd1);
            chk("t2_step", val_q[k] - val_q[k-1], 64'd4);
         end
      end

      // Fairness: requesters 0 and 3 never drop
      clear_log();
      drop = '0;
      req = 4'b1001;
      repeat (16) cyc();
      req = '0;
      repeat (4) cyc();
      chk("t3_nack", 64'(ack_c.size()), 64'd4);
      chk("t3_g0", 64'(ack_v[0]), 64'h1);
      chk("t3_g1", 64'(ack_v[1]), 64'h8);
      chk("t3_g2", 64'(ack_v[2]), 64'h1);
      chk("t3_g3", 64'(ack_v[3]), 64'h8);

      // Start/stop together, then frozen sampling
      start = 1'b1;
      stop = 1'b1;
      cyc();
      start = 1'b0;
      stop = 1'b0;
      chk("t4_both", 64'(en), 64'd0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("t4_start", 64'(en), 64'd1);
      repeat (3) cyc();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("t4_stop", 64'(en), 64'd0);
      clear_log();
      drop = '1;
      req = 4'b0010;
      repeat (5) cyc();
      req = 4'b0010;
      repeat (5) cyc();
      chk("t4_nack", 64'(ack_c.size()), 64'd2);
      chk("t4_ack0", 64'(ack_v[0]), 64'h2);
      chk("t4_ack1", 64'(ack_v[1]), 64'h2);
      chk("t4_same", val_q[1], val_q[0]);
      chk("t4_nz", 64'(val_q[0] != 0), 64'd1);

      // Reset during WAIT aborts, pending request restarts after release
      req = 4'b0010;
      cyc();
      cyc();
      chk("t5_wait", 64'(busy && !ts), 64'd1);
      rst = 1'b1;
      #1;
      chk("t5_async_ack", 64'(ack), 64'd0);
      chk("t5_async_busy", 64'(busy), 64'd0);
      chk("t5_async_val", value, 64'd0);
      cyc();
      cyc();
      rst = 1'b0;
      clear_log();
      t0 = cyc_n;
      repeat (6) cyc();
      chk("t5_nack", 64'(ack_c.size()), 64'd1);
      chk("t5_cyc", 64'(ack_c[0]), 64'(t0 + 3));
      chk("t5_ack", 64'(ack_v[0]), 64'h2);

      // Start accepted while a sample is in flight; grant wraps to 0
      clear_log();
      req = 4'b0001;
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (4) cyc();
      chk("t6_en", 64'(en), 64'd1);
      chk("t6_ack", 64'(ack_v[0]), 64'h1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
